// File: rtl/level_load_ctrl.sv
`timescale 1ns/1ps
// Level loader: walks one level's bricks out of the level ROM and hands each
// non-empty brick (pixel position, RAM index, type) to the brick RAM/plotter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start
//   FETCH   | rom_address presented for the current brick
//   CAPTURE | rom_data valid; register type, position and RAM index
//   WRITE   | load asserted until ready accepts the brick
//   DONE    | one-cycle done pulse, then back to IDLE
module level_load_ctrl #(
  parameter int COLS       = 10,
  parameter int ROWS       = 8,
  parameter int NUM_LEVELS = 12,
  parameter int BRICK_W    = 32,
  parameter int BRICK_H    = 16,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 40,
  parameter int SKIP_EMPTY = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [9:0] selection,
  input  logic [2:0] rom_data,
  input  logic       ready,
  output logic [9:0] rom_address,
  output logic       load,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic [9:0] address,
  output logic [2:0] brick_type,
  output logic       busy,
  output logic       done
);

  localparam int BRICKS = COLS * ROWS;
  localparam int IDX_W  = $clog2(BRICKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BRICKS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, DONE} state_t;

  state_t           state;
  logic [9:0]       sel;
  logic [IDX_W-1:0] index;

  logic [9:0]       sel_eff;
  logic [9:0]       start_addr;
  logic [9:0]       next_addr;
  logic [9:0]       col_x;
  logic [9:0]       row_y;
  logic [IDX_W-1:0] index_nxt;
  logic             is_last;
  logic             skip;

  // Out-of-range level numbers fall back to level 0; pixel math truncates to 10 bits.
  always_comb begin
    sel_eff    = (int'(selection) >= NUM_LEVELS) ? 10'd0 : selection;
    start_addr = 10'(int'(sel_eff) * BRICKS);
    index_nxt  = index + 1'b1;
    next_addr  = 10'(int'(sel) * BRICKS + int'(index_nxt));
    col_x      = 10'(X_ORIGIN + (int'(index) % COLS) * BRICK_W);
    row_y      = 10'(Y_ORIGIN + (int'(index) / COLS) * BRICK_H);
    is_last    = (index == LAST_IDX);
    skip       = (SKIP_EMPTY != 0) && (rom_data == 3'd0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      sel         <= '0;
      index       <= '0;
      rom_address <= '0;
      load        <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      address     <= '0;
      brick_type  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel         <= sel_eff;
            index       <= '0;
            rom_address <= start_addr;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          brick_type <= rom_data;
          x_out      <= col_x;
          y_out      <= row_y;
          address    <= 10'(index);
          if (!skip) begin
            load  <= 1'b1;
            state <= WRITE;
          end else if (is_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            index       <= index_nxt;
            rom_address <= next_addr;
            state       <= FETCH;
          end
        end
        WRITE: begin
          if (ready) begin
            load <= 1'b0;
            if (is_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              index       <= index_nxt;
              rom_address <= next_addr;
              state       <= FETCH;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_level_load_ctrl.sv
`timescale 1ns/1ps
// Bench for level_load_ctrl: synchronous ROM model, transfer monitor and an
// arithmetic reference of which bricks a level should produce.
module tb_level_load_ctrl;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [9:0] selection;
  logic [2:0] rom_data;
  logic       ready;
  logic [9:0] rom_address;
  logic       load;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic [9:0] address;
  logic [2:0] brick_type;
  logic       busy;
  logic       done;

  typedef struct {
    int ra;
    int x;
    int y;
    int a;
    int t;
    int ld;
  } xfer_t;

  xfer_t      got_q[$];
  xfer_t      exp_q[$];
  xfer_t      hold_q[$];
  logic [2:0] rom_mem [0:1023];

  int vectors     = 0;
  int miscompares = 0;
  int g_rdy_rand   = 0;
  int g_restart_at = -1;
  int g_bp_addr    = -1;
  int g_abort_addr = -1;

  level_load_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .selection  (selection),
    .rom_data   (rom_data),
    .ready      (ready),
    .rom_address(rom_address),
    .load       (load),
    .x_out      (x_out),
    .y_out      (y_out),
    .address    (address),
    .brick_type (brick_type),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_address];

  function automatic xfer_t snap();
    xfer_t r;
    r.ra = int'(rom_address);
    r.x  = int'(x_out);
    r.y  = int'(y_out);
    r.a  = int'(address);
    r.t  = int'(brick_type);
    r.ld = int'(load);
    return r;
  endfunction

  // Reference: every non-zero brick of the (clamped) level, in index order.
  function automatic void build_exp(input int sel_in);
    int s;
    s = (sel_in >= 12) ? 0 : sel_in;
    exp_q.delete();
    for (int i = 0; i < 80; i++) begin
      xfer_t r;
      r.t = int'(rom_mem[s * 80 + i]);
      if (r.t != 0) begin
        r.ra = s * 80 + i;
        r.x  = (i % 10) * 32;
        r.y  = 40 + (i / 10) * 16;
        r.a  = i;
        r.ld = 1;
        exp_q.push_back(r);
      end
    end
  endfunction

  task automatic set_knobs(input int rdy_rand, input int restart_at, input int bp_addr,
                           input int abort_addr);
    g_rdy_rand   = rdy_rand;
    g_restart_at = restart_at;
    g_bp_addr    = bp_addr;
    g_abort_addr = abort_addr;
  endtask

  // Starts a load, records every accepted transfer and stops at the done pulse
  // (or on abort / cycle budget). cycles counts edges from the start edge.
  task automatic do_load(input int sel_in, output int cycles, output int dones);
    int hold_cnt;
    bit arm;
    bit holding;
    hold_cnt = 0;
    arm      = 1'b0;
    holding  = 1'b0;
    got_q.delete();
    hold_q.delete();
    cycles = -1;
    dones  = 0;
    @(posedge clk); #1;
    selection = 10'(sel_in);
    start     = 1'b1;
    ready     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (load && ready) begin
        got_q.push_back(snap());
        if (g_bp_addr >= 0 && int'(address) == g_bp_addr - 1) arm = 1'b1;
        if (g_abort_addr >= 0 && int'(address) == g_abort_addr) begin
          #2;
          resetn = 1'b0;
          break;
        end
      end else if (holding && load) begin
        hold_q.push_back(snap());
        hold_cnt++;
        if (hold_cnt == 5) begin
          ready   = 1'b1;
          holding = 1'b0;
          got_q.push_back(snap());
        end
      end
      if (done) begin
        dones++;
        cycles = k - 1;
        break;
      end
      @(posedge clk); #1;
      if (arm) begin
        ready   = 1'b0;
        arm     = 1'b0;
        holding = 1'b1;
      end else if (g_rdy_rand != 0) begin
        ready = 1'($urandom_range(0, 1));
      end
      start = (k == g_restart_at);
      if (k == g_restart_at) selection = 10'd5;
    end
  endtask

  task automatic test_reset();
    logic [48:0] outs;
    resetn = 1'b1; start = 1'b0; ready = 1'b1; selection = '0;
    #2 resetn = 1'b0;
    #1 outs = {rom_address, load, x_out, y_out, address, brick_type, busy, done};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_initial outputs=%h expected 0", outs);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1 selection = 10'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_busy busy=%b expected 1", busy);
    end
    #2 resetn = 1'b0;
    #1 outs = {rom_address, load, x_out, y_out, address, brick_type, busy, done};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_async outputs=%h expected 0", outs);
    end
    #1 resetn = 1'b1;
  endtask

  task automatic test_full_load();
    int cyc, dn;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'd1;
    set_knobs(0, -1, -1, -1);
    do_load(2, cyc, dn);
    build_exp(2);
    vectors++;
    if (dn != 1 || cyc != 240) begin
      miscompares++;
      $display("FAIL full_done dones=%0d cycles=%0d expected 1/240", dn, cyc);
    end
    vectors++;
    if (got_q.size() != 80) begin
      miscompares++;
      $display("FAIL full_count got=%0d expected 80", got_q.size());
    end else begin
      vectors++;
      if (got_q[0].ra != 160 || got_q[79].ra != 239) begin
        miscompares++;
        $display("FAIL full_rom_addr first=%0d last=%0d expected 160/239", got_q[0].ra, got_q[79].ra);
      end
      vectors++;
      if (got_q[79].x != 288 || got_q[79].y != 152 || got_q[79].a != 79) begin
        miscompares++;
        $display("FAIL full_last x=%0d y=%0d a=%0d expected 288/152/79",
                 got_q[79].x, got_q[79].y, got_q[79].a);
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_done_width done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_random();
    int cyc, dn, sel;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 1024; i++)
        rom_mem[i] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      sel = $urandom_range(0, 15);
      set_knobs(1, -1, -1, -1);
      do_load(sel, cyc, dn);
      build_exp(sel);
      vectors++;
      if (dn != 1 || got_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand_count sel=%0d dones=%0d got=%0d expected 1/%0d",
                 sel, dn, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i].ra != exp_q[i].ra || got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y ||
            got_q[i].a != exp_q[i].a || got_q[i].t != exp_q[i].t || got_q[i].ld != 1) begin
          miscompares++;
          $display("FAIL rand_xfer[%0d] got ra=%0d x=%0d y=%0d a=%0d t=%0d expected ra=%0d x=%0d y=%0d a=%0d t=%0d",
                   i, got_q[i].ra, got_q[i].x, got_q[i].y, got_q[i].a, got_q[i].t,
                   exp_q[i].ra, exp_q[i].x, exp_q[i].y, exp_q[i].a, exp_q[i].t);
        end
      end
    end
    ready = 1'b1;
  endtask

  task automatic test_backpressure();
    int cyc, dn, n11;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'd1;
    set_knobs(0, -1, 11, -1);
    do_load(0, cyc, dn);
    vectors++;
    if (hold_q.size() != 5) begin
      miscompares++;
      $display("FAIL bp_hold_len got=%0d expected 5", hold_q.size());
    end
    foreach (hold_q[i]) begin
      vectors++;
      if (hold_q[i].ld != 1 || hold_q[i].x != 32 || hold_q[i].y != 56 || hold_q[i].a != 11) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] ld=%0d x=%0d y=%0d a=%0d expected 1/32/56/11",
                 i, hold_q[i].ld, hold_q[i].x, hold_q[i].y, hold_q[i].a);
      end
    end
    n11 = 0;
    foreach (got_q[i]) if (got_q[i].a == 11) n11++;
    vectors++;
    if (n11 != 1 || got_q.size() != 80 || dn != 1) begin
      miscompares++;
      $display("FAIL bp_xfers n11=%0d total=%0d dones=%0d expected 1/80/1", n11, got_q.size(), dn);
    end
  endtask

  task automatic test_skip();
    int cyc, dn;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'd3;
    rom_mem[0]  = 3'd0;
    rom_mem[79] = 3'd0;
    set_knobs(0, -1, -1, -1);
    do_load(0, cyc, dn);
    vectors++;
    if (got_q.size() != 78 || dn != 1) begin
      miscompares++;
      $display("FAIL skip_count got=%0d dones=%0d expected 78/1", got_q.size(), dn);
    end else begin
      vectors++;
      if (got_q[0].a != 1 || got_q[0].t != 3 || got_q[77].a != 78) begin
        miscompares++;
        $display("FAIL skip_ends first_a=%0d first_t=%0d last_a=%0d expected 1/3/78",
                 got_q[0].a, got_q[0].t, got_q[77].a);
      end
    end
  endtask

  task automatic test_busy_start();
    int cyc, dn;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'($urandom_range(1, 7));
    set_knobs(0, 20, -1, -1);
    do_load(15, cyc, dn);
    build_exp(15);
    vectors++;
    if (got_q.size() != 80 || dn != 1 || cyc != 240) begin
      miscompares++;
      $display("FAIL busy_start count=%0d dones=%0d cycles=%0d expected 80/1/240", got_q.size(), dn, cyc);
    end else begin
      vectors++;
      if (got_q[0].ra != 0 || got_q[79].ra != 79 || got_q[40].t != exp_q[40].t) begin
        miscompares++;
        $display("FAIL busy_start_addr first=%0d last=%0d t40=%0d expected 0/79/%0d",
                 got_q[0].ra, got_q[79].ra, got_q[40].t, exp_q[40].t);
      end
    end
    start = 1'b1;
    selection = 10'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || load !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL start_in_done busy=%b load=%b done=%b expected 0/0/0", busy, load, done);
      end
    end
  endtask

  task automatic test_mid_reset();
    int cyc, dn;
    logic [48:0] outs;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'd2;
    set_knobs(0, -1, -1, 40);
    do_load(0, cyc, dn);
    #1 outs = {rom_address, load, x_out, y_out, address, brick_type, busy, done};
    vectors++;
    if (outs !== '0 || dn != 0 || got_q.size() != 41) begin
      miscompares++;
      $display("FAIL mid_reset outs=%h dones=%0d xfers=%0d expected 0/0/41", outs, dn, got_q.size());
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_done done=%b expected 0", done);
    end
    resetn = 1'b1;
    set_knobs(0, -1, -1, -1);
    do_load(0, cyc, dn);
    vectors++;
    if (got_q.size() != 80 || dn != 1 || got_q[0].a != 0) begin
      miscompares++;
      $display("FAIL restart count=%0d dones=%0d first_a=%0d expected 80/1/0",
               got_q.size(), dn, (got_q.size() > 0) ? got_q[0].a : -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'd0;
    test_reset();
    test_full_load();
    test_backpressure();
    test_skip();
    test_busy_start();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/level_load_ctrl.md
LEVEL_LOAD_CTRL -- requirements
Module: level_load_ctrl

Interface
REQ-001 Parameters SHALL be:
  - COLS, 10, bricks per row
  - ROWS, 8, brick rows
  - NUM_LEVELS, 12, levels stored in ROM
  - BRICK_W, 32, brick width in pixels
  - BRICK_H, 16, brick height in pixels
  - X_ORIGIN, 0, pixel x of brick (0,0)
  - Y_ORIGIN, 40, pixel y of brick (0,0)
  - SKIP_EMPTY, 1, when 1 do not emit type-0 bricks
REQ-002 Ports SHALL be:
  - clk  in  1  sole clock, rising edge
  - resetn  in  1  asynchronous active-low reset
  - start  in  1  request a level load
  - selection  in  10  level number
  - rom_data  in  3  brick type from level ROM, valid the cycle after rom_address
  - ready  in  1  brick-RAM/plotter accepts the current write
  - rom_address  out  10  level ROM address
  - load  out  1  write valid
  - x_out  out  10  brick pixel x
  - y_out  out  10  brick pixel y
  - address  out  10  brick RAM index
  - brick_type  out  3  type being written
  - busy  out  1  load in progress
  - done  out  1  one-cycle completion pulse

Function
REQ-003 FSM states SHALL be IDLE, FETCH, CAPTURE, WRITE and DONE.
REQ-004 In IDLE, start=1 at an edge SHALL:
  - latch selection, treating any value >= NUM_LEVELS as 0
  - clear the brick index to 0
  - move to FETCH
REQ-005 start SHALL be ignored in every state other than IDLE.
REQ-006 busy SHALL be 1 in FETCH, CAPTURE and WRITE, and 0 in IDLE and DONE.
REQ-007 In FETCH, rom_address SHALL equal sel*COLS*ROWS + index, and the next state SHALL be CAPTURE.
REQ-008 rom_address SHALL hold its last value in all other states; the product SHALL fit in 10 bits for the default parameters (max 959).
REQ-009 In CAPTURE, rom_data SHALL be registered into brick_type; col = index mod COLS and row = index div COLS.
REQ-010 CAPTURE SHALL register these outputs, each 10 bits wide, truncated on overflow:
  - x_out = X_ORIGIN + col*BRICK_W
  - y_out = Y_ORIGIN + row*BRICK_H
  - address = index
REQ-011 From CAPTURE, if SKIP_EMPTY=1 and rom_data=0, the brick SHALL be skipped: go to DONE if index = COLS*ROWS-1, else increment index and go to FETCH.
REQ-012 Otherwise, CAPTURE SHALL go to WRITE.
REQ-013 In WRITE, load SHALL be 1, and x_out, y_out, address and brick_type SHALL stay stable until the transfer edge (load=1 and ready=1).
REQ-014 At the transfer edge, the FSM SHALL go to DONE if index = COLS*ROWS-1, else increment index and go to FETCH.
REQ-015 Exactly one transfer per emitted brick; load SHALL be 0 outside WRITE.
REQ-016 Latency: start at edge E0 -> FETCH in cycle E0..E1, CAPTURE in E1..E2, load=1 from E2. With ready held 1, each brick SHALL take 3 cycles.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 start=1 during DONE SHALL be ignored.
REQ-019 The brick index SHALL never exceed COLS*ROWS-1 and SHALL not wrap.
REQ-020 An unaccepted load SHALL wait indefinitely; there is no timeout.

Reset
REQ-021 resetn=0 SHALL immediately, without waiting for clk, force state IDLE and clear all registers.
REQ-022 Output values during reset SHALL be: load, busy and done 0; rom_address, x_out, y_out, address and brick_type 0.
REQ-023 Reset mid-load SHALL abandon the load with no done pulse; the next start SHALL begin again at index 0.

Verification
REQ-024 Reset check: assert resetn=0 between edges -> all outputs 0 before the next clk edge.
REQ-025 Full load: selection=2, all rom_data=1, ready=1 ->
  - 80 transfers; first rom_address=160, last rom_address=239
  - last transfer has x_out=288, y_out=152, address=79
  - done pulses 1 cycle, exactly 240 cycles after start
REQ-026 Backpressure: hold ready=0 for 5 cycles on brick 11 -> load stays 1 with x_out=32, y_out=56, address=11 constant; a single transfer occurs when ready returns to 1.
REQ-027 Skip: rom_data=0 at indices 0 and 79, others 3 ->
  - 78 transfers; first transfer has address=1
  - done still pulses after index 79
REQ-028 Start while busy or out of range:
  - second start during a load -> no effect
  - selection=15 -> rom_address begins at 0
REQ-029 Mid-load reset: pulse resetn low at index 40, then start -> first transfer has address=0, and no done pulse occurs before the restart.
